wb_stage: RTL and testbench

Fifth and final pipeline stage. Consumes the memory-stage output bus, commits results to the register file, and owns the CP0 register file. Detects exceptions and interrupts, and `eret`. On any of these it raises a single-cycle flush to all upstream stages and supplies the redirect PC.

---
 rtl/wb_stage_pkg.sv | 40 ++++
 rtl/wb_stage_cp0_regfile.sv | 130 +++++++++++++
 rtl/wb_stage.sv | 90 +++++++++
 tb/tb_wb_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared writeback/CP0 definitions: bus layout, CP0 numbers, excodes.
// Optional timer: define CP0_TIMER_EN.
package wb_stage_pkg;

  localparam int MS_TO_WS_BUS_WD = 149;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam logic [31:0] STATUS_WMASK = 32'h0000FF03;

  typedef struct packed {
    logic [31:0] rt_value;
    logic        eret;
    logic        bd;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic        res_from_cp0;
    logic [31:0] alu_result;
    logic        ex;
    logic [4:0]  excode;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

endpackage

// File: rtl/wb_stage_cp0_regfile.sv
// CP0 state, read mux, interrupt request and optional timer.
// Optional timer: define CP0_TIMER_EN.
module cp0_regfile
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] STATUS_RST = 32'h00400000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  ext_int_in,
  input  logic        mtc0_we_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic        take_ex_i,
  input  logic [4:0]  excode_i,
  input  logic        bd_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] badv_i,
  input  logic        eret_i,
  output logic [31:0] rdata_o,
  output logic [31:0] epc_o,
  output logic        int_req_o
);

  logic [31:0] status_q;
  logic [31:0] epc_q;
  logic [31:0] badv_q;
  logic        bd_q;
  logic [7:0]  ip_q;
  logic [4:0]  exc_q;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic        ip7;
  logic [31:0] cause;

  logic wr_status, wr_cause, wr_epc;
  assign wr_status = mtc0_we_i & (addr_i == CP0_STATUS);
  assign wr_cause  = mtc0_we_i & (addr_i == CP0_CAUSE);
  assign wr_epc    = mtc0_we_i & (addr_i == CP0_EPC);

`ifdef CP0_TIMER_EN
  logic        tick_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        ti_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q    <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      tick_q <= ~tick_q;
      if (mtc0_we_i && addr_i == CP0_COUNT)
        count_q <= wdata_i;
      else if (tick_q)
        count_q <= count_q + 32'd1;
      if (mtc0_we_i && addr_i == CP0_COMPARE) begin
        compare_q <= wdata_i;
        ti_q      <= 1'b0;
      end else if (count_q == compare_q && compare_q != '0) begin
        ti_q <= 1'b1;
      end
    end
  end
  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;
  assign ip7     = ext_int_in[5] | ti_q;
`else
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
  assign ip7     = ext_int_in[5];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= STATUS_RST;
      epc_q    <= '0;
      badv_q   <= '0;
      bd_q     <= 1'b0;
      ip_q     <= '0;
      exc_q    <= '0;
    end else begin
      ip_q[7:2] <= {ip7, ext_int_in[4:0]};
      if (wr_cause)
        ip_q[1:0] <= wdata_i[9:8];
      if (wr_status)
        status_q <= (status_q & ~STATUS_WMASK)
                  | (wdata_i & STATUS_WMASK);
      if (wr_epc)
        epc_q <= wdata_i;
      if (take_ex_i) begin
        exc_q       <= excode_i;
        status_q[1] <= 1'b1;
        // nested faults keep the original return point
        if (!status_q[1]) begin
          epc_q <= bd_i ? pc_i - 32'd4 : pc_i;
          bd_q  <= bd_i;
        end
        if (excode_i == EXC_ADEL || excode_i == EXC_ADES)
          badv_q <= badv_i;
      end else if (eret_i) begin
        status_q[1] <= 1'b0;
      end
    end
  end

  assign cause = {bd_q, ti, 14'b0, ip_q, 1'b0, exc_q, 2'b0};

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      CP0_BADVADDR: rdata_o = badv_q;
      CP0_COUNT:    rdata_o = count;
      CP0_COMPARE:  rdata_o = compare;
      CP0_STATUS:   rdata_o = status_q;
      CP0_CAUSE:    rdata_o = cause;
      CP0_EPC:      rdata_o = epc_q;
      default:      rdata_o = '0;
    endcase
  end

  assign epc_o     = epc_q;
  assign int_req_o = status_q[0] & ~status_q[1]
                   & |(ip_q & status_q[15:8]);

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: regfile commit, exception/eret flush, CP0 owner.
// Optional timer: define CP0_TIMER_EN.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int          MS_TO_WS_BUS_WD = wb_stage_pkg::MS_TO_WS_BUS_WD,
  parameter logic [31:0] EX_ENTRY        = 32'hBFC00380,
  parameter logic [31:0] STATUS_RST      = 32'h00400000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ws_allowin,
  input  logic [5:0]                 ext_int_in,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic [4:0]                 ws_dest,
  output logic [31:0]                ws_fwd_data,
  output logic                       ex_from_ws,
  output logic [31:0]                ex_target,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);

  logic      ws_valid_q;
  ms_to_ws_t bus_q;
  logic      int_req;
  logic      take_ex;
  logic      eret_go;
  logic [4:0]  excode;
  logic [31:0] cp0_rdata;
  logic [31:0] epc;

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      ws_valid_q <= ms_to_ws_valid & ~ex_from_ws;
      if (ms_to_ws_valid)
        bus_q <= ms_to_ws_t'(ms_to_ws_bus);
    end
  end

  assign take_ex = ws_valid_q & (bus_q.ex | int_req);
  assign eret_go = ws_valid_q & bus_q.eret & ~take_ex;
  assign excode  = int_req ? EXC_INT : bus_q.excode;

  cp0_regfile #(
    .STATUS_RST(STATUS_RST)
  ) u_cp0 (
    .clk       (clk),
    .reset     (reset),
    .ext_int_in(ext_int_in),
    .mtc0_we_i (ws_valid_q & bus_q.mtc0_we & ~take_ex),
    .addr_i    (bus_q.cp0_addr),
    .wdata_i   (bus_q.rt_value),
    .take_ex_i (take_ex),
    .excode_i  (excode),
    .bd_i      (bus_q.bd),
    .pc_i      (bus_q.pc),
    .badv_i    (bus_q.alu_result),
    .eret_i    (eret_go),
    .rdata_o   (cp0_rdata),
    .epc_o     (epc),
    .int_req_o (int_req)
  );

  assign ws_allowin  = 1'b1;
  assign ex_from_ws  = take_ex | eret_go;
  assign ex_target   = eret_go ? epc
                     : take_ex ? EX_ENTRY : 32'h0;

  assign rf_we       = ws_valid_q & bus_q.gr_we & ~take_ex;
  assign rf_waddr    = bus_q.dest;
  assign rf_wdata    = bus_q.res_from_cp0 ? cp0_rdata
                                          : bus_q.final_result;
  assign ws_dest     = rf_we ? bus_q.dest : 5'd0;
  assign ws_fwd_data = rf_wdata;

  assign debug_wb_pc       = bus_q.pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = bus_q.dest;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed instructions, monitor checks.
// Timer expectations follow CP0_TIMER_EN.
module tb_wb_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_to_ws_valid;
  logic [148:0] ms_to_ws_bus;
  logic         ws_allowin;
  logic [5:0]   ext_int_in;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [4:0]   ws_dest;
  logic [31:0]  ws_fwd_data;
  logic         ex_from_ws;
  logic [31:0]  ex_target;
  logic [31:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_wen;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  wb_stage dut (
    .clk              (clk),
    .reset            (reset),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ms_to_ws_bus     (ms_to_ws_bus),
    .ws_allowin       (ws_allowin),
    .ext_int_in       (ext_int_in),
    .rf_we            (rf_we),
    .rf_waddr         (rf_waddr),
    .rf_wdata         (rf_wdata),
    .ws_dest          (ws_dest),
    .ws_fwd_data      (ws_fwd_data),
    .ex_from_ws       (ex_from_ws),
    .ex_target        (ex_target),
    .debug_wb_pc      (debug_wb_pc),
    .debug_wb_rf_wen  (debug_wb_rf_wen),
    .debug_wb_rf_wnum (debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] EXV = 32'hBFC00380;
`ifdef CP0_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ex;
    logic [31:0] tgt;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h", nm, act, req);
  endtask

  function automatic logic [148:0] mk(
      input logic [31:0] rt, input logic eret, input logic bd,
      input logic mtc0, input logic [4:0] caddr, input logic rfc0,
      input logic [31:0] alu, input logic ex, input logic [4:0] exc,
      input logic gwe, input logic [4:0] dest,
      input logic [31:0] fres, input logic [31:0] pc);
    return {rt, eret, bd, mtc0, caddr, rfc0, alu, ex, exc,
            gwe, dest, fres, pc};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rf_we === 1'b1 || ex_from_ws === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {31'b0, ex_from_ws}, 32'hFFFFFFFF);
      end else begin
        e = sb.pop_front();
        chk("rf_we", {31'b0, rf_we}, {31'b0, e.we});
        chk("ex_from_ws", {31'b0, ex_from_ws}, {31'b0, e.ex});
        chk("ex_target", ex_target, e.tgt);
        chk("debug_wb_pc", debug_wb_pc, e.pc);
        if (e.we) begin
          chk("rf_waddr", {27'b0, rf_waddr}, {27'b0, e.waddr});
          chk("rf_wdata", rf_wdata, e.wdata);
          chk("ws_dest", {27'b0, ws_dest}, {27'b0, e.waddr});
          chk("ws_fwd_data", ws_fwd_data, e.wdata);
          chk("dbg_wen", {28'b0, debug_wb_rf_wen}, 32'hF);
          chk("dbg_wnum", {27'b0, debug_wb_rf_wnum}, {27'b0, e.waddr});
          chk("dbg_wdata", debug_wb_rf_wdata, e.wdata);
        end
      end
    end
  end

  task automatic issue(input logic [148:0] b);
    @(posedge clk); #1;
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = b;
    @(posedge clk); #1;
    ms_to_ws_valid = 1'b0;
  endtask

  task automatic push(input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic ex,
                      input logic [31:0] tgt, input logic [31:0] pc);
    exp_t e;
    e.we = we; e.waddr = wa; e.wdata = wd;
    e.ex = ex; e.tgt = tgt; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic alu(input logic [4:0] d, input logic [31:0] v,
                     input logic [31:0] pc);
    push(1'b1, d, v, 1'b0, 32'h0, pc);
    issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, d, v, pc));
  endtask

  task automatic mfc0(input logic [4:0] a, input logic [4:0] d,
                      input logic [31:0] req);
    push(1'b1, d, req, 1'b0, 32'h0, 32'hBFC00F00);
    issue(mk(0, 0, 0, 0, a, 1, 0, 0, 0, 1, d, 32'h0, 32'hBFC00F00));
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] v);
    issue(mk(v, 0, 0, 1, a, 0, 0, 0, 0, 0, 0, 0, 32'hBFC00F04));
  endtask

  task automatic fault(input logic [4:0] exc, input logic bd,
                       input logic eret, input logic [31:0] alu_r,
                       input logic [31:0] pc);
    push(1'b0, 0, 0, 1'b1, EXV, pc);
    issue(mk(0, eret, bd, 0, 0, 0, alu_r, 1, exc, 0, 0, 0, pc));
  endtask

  task automatic eret(input logic [31:0] tgt, input logic [31:0] pc);
    push(1'b0, 0, 0, 1'b1, tgt, pc);
    issue(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, pc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus = '0;
    ext_int_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_allowin", {31'b0, ws_allowin}, 32'h1);
    chk("rst_rf_we", {31'b0, rf_we}, 32'h0);
    chk("rst_ex", {31'b0, ex_from_ws}, 32'h0);
    chk("rst_target", ex_target, 32'h0);
    chk("rst_wdata", rf_wdata, 32'h0);
    chk("rst_dbg_pc", debug_wb_pc, 32'h0);
    chk("rst_dbg_wen", {28'b0, debug_wb_rf_wen}, 32'h0);
    chk("rst_dest", {27'b0, ws_dest}, 32'h0);

    alu(5'd3, 32'd5, 32'hBFC00010);
    fault(5'h08, 1'b1, 1'b0, 32'h0, 32'hBFC00104);
    mfc0(5'd14, 5'd8, 32'hBFC00100);
    mfc0(5'd13, 5'd9, 32'h80000020);
    mtc0(5'd14, 32'h00001234);
    eret(32'h00001234, 32'hBFC00108);
    mfc0(5'd12, 5'd10, 32'h00400000);

    mtc0(5'd12, 32'h0000FF01);
    mfc0(5'd12, 5'd10, 32'h0040FF01);
    ext_int_in = 6'b000001;
    repeat (2) @(posedge clk);
    push(1'b0, 0, 0, 1'b1, EXV, 32'hBFC00200);
    issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd4, 32'd7,
             32'hBFC00200));
    mfc0(5'd13, 5'd11, 32'h00000400);
    mfc0(5'd14, 5'd12, 32'hBFC00200);

    eret(32'hBFC00200, 32'hBFC00204);
    push(1'b0, 0, 0, 1'b1, EXV, 32'hBFC00300);
    issue(mk(32'hDEAD, 0, 0, 1, 5'd14, 0, 0, 0, 0, 0, 0, 0,
             32'hBFC00300));
    mfc0(5'd14, 5'd12, 32'hBFC00300);
    ext_int_in = '0;
    repeat (2) @(posedge clk);
    eret(32'hBFC00300, 32'hBFC00304);

    fault(5'h0C, 1'b0, 1'b1, 32'h0, 32'hBFC00400);
    mfc0(5'd12, 5'd13, 32'h0040FF03);
    mfc0(5'd13, 5'd13, 32'h00000030);

    fault(5'h04, 1'b0, 1'b0, 32'h80000003, 32'hBFC00600);
    mfc0(5'd8, 5'd14, 32'h80000003);
    mfc0(5'd14, 5'd14, 32'hBFC00400);
    mfc0(5'd13, 5'd14, 32'h00000010);
    mfc0(5'd3, 5'd15, 32'h0);

    mtc0(5'd12, 32'h0);
    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'd4);
    mfc0(5'd11, 5'd16, TIMER ? 32'd4 : 32'd0);
    repeat (20) @(posedge clk);
    mfc0(5'd13, 5'd17, TIMER ? 32'h40008010 : 32'h00000010);
    mtc0(5'd11, 32'h100);
    mfc0(5'd13, 5'd17, 32'h00000010);

    push(1'b0, 0, 0, 1'b1, EXV, 32'hBFC00500);
    @(posedge clk); #1;
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus = mk(0, 0, 0, 0, 0, 0, 0, 1, 5'h08, 0, 0, 0,
                      32'hBFC00500);
    @(posedge clk); #1;
    ms_to_ws_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mfc0(5'd14, 5'd18, 32'h0);
    mfc0(5'd12, 5'd18, 32'h00400000);
    mfc0(5'd13, 5'd18, 32'h0);

    repeat (4) @(posedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
